// File: rtl/pla_pkg.sv
// Shared sizes, fuse-map index helpers and loader state encoding for the
// 3-input / 2-output PLA and its serial configuration loader.
package pla_pkg;

  localparam int N_IN      = 3;
  localparam int N_TERMS   = 4;
  localparam int N_OUT     = 2;

  localparam int AND_BITS  = N_TERMS * 2 * N_IN;
  localparam int OR_BITS   = N_OUT * N_TERMS;
  localparam int FUSE_BITS = AND_BITS + OR_BITS;

  localparam int AND_IDX_W = $clog2(AND_BITS);
  localparam int OR_IDX_W  = $clog2(OR_BITS);
  localparam int FIDX_W    = $clog2(FUSE_BITS);
  localparam int CNT_W     = $clog2(FUSE_BITS + 1);

  typedef logic [AND_IDX_W-1:0] and_idx_t;
  typedef logic [OR_IDX_W-1:0]  or_idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [FUSE_BITS-1:0] fuse_map_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK
  } state_e;

  // Literal fuse of input i in term t; comp selects the complemented literal.
  function automatic and_idx_t and_idx(input int t, input int i, input logic comp);
    return and_idx_t'(t * 2 * N_IN + 2 * i + (comp ? 1 : 0));
  endfunction

  // Position of the (output o, term t) fuse inside the OR plane, which
  // itself starts at AND_BITS in the full fuse map.
  function automatic or_idx_t or_idx(input int o, input int t);
    return or_idx_t'(o * N_TERMS + t);
  endfunction

endpackage

// File: rtl/pla_eval.sv
// Combinational PLA core: evaluates the active AND/OR fuse planes against
// the inputs; the caller registers the result.
module pla_eval
  import pla_pkg::*;
(
  input  logic [AND_BITS-1:0] and_plane_i,
  input  logic [OR_BITS-1:0]  or_plane_i,
  input  logic [N_IN-1:0]     in_vec_i,
  output logic [N_OUT-1:0]    out_o
);

  logic [N_TERMS-1:0][N_IN-1:0] true_en;
  logic [N_TERMS-1:0][N_IN-1:0] comp_en;
  logic [N_TERMS-1:0]           term;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    true_en = '0;
    comp_en = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      for (int i = 0; i < N_IN; i++) begin
        true_en[t][i] = and_plane_i[and_idx(t, i, 1'b0)];
        comp_en[t][i] = and_plane_i[and_idx(t, i, 1'b1)];
      end
    end
  end

  // An empty term is unused and reads 0; enabling both literals of one
  // input always produces a mismatch on that input, so the term reads 0.
  always_comb begin
    term = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      term[t] = (|(true_en[t] | comp_en[t]))
              & ~(|(true_en[t] & ~in_vec_i))
              & ~(|(comp_en[t] & in_vec_i));
    end
  end

  always_comb begin
    out_o = '0;
    for (int o = 0; o < N_OUT; o++) begin
      for (int t = 0; t < N_TERMS; t++) begin
        out_o[o] = out_o[o] | (or_plane_i[or_idx(o, t)] & term[t]);
      end
    end
  end

endmodule

// File: rtl/pla_cfg_loader.sv
// Serial fuse loader with even-parity check and atomic commit, wrapped around
// a registered 3-input / 2-output PLA.
module pla_cfg_loader
  import pla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             busy,
  input  logic [N_IN-1:0]  in_vec,
  output logic [N_OUT-1:0] out_vec
);

  localparam cnt_t PARITY_POS = cnt_t'(FUSE_BITS);

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  fuse_map_t        shadow_q, shadow_d;
  fuse_map_t        active_q, active_d;
  logic             par_q, par_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [N_OUT-1:0] out_q, out_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    par_d    = par_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          par_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        // A restart wins over any bit offered in the same cycle.
        if (cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
          par_d    = 1'b0;
        end else if (cfg_valid) begin
          par_d = par_q ^ cfg_bit;
          if (cnt_q == PARITY_POS) begin
            state_d = ST_CHECK;
          end else begin
            shadow_d[cnt_q[FIDX_W-1:0]] = cfg_bit;
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (!par_q) begin
          active_d = shadow_q;
          done_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  pla_eval u_eval (
    .and_plane_i (active_q[AND_BITS-1:0]),
    .or_plane_i  (active_q[FUSE_BITS-1:AND_BITS]),
    .in_vec_i    (in_vec),
    .out_o       (out_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the fuse maps are plain registers and are reset too, so a reset leaves the PLA unprogrammed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      par_q    <= par_d;
      done_q   <= done_d;
      err_q    <= err_d;
      out_q    <= out_d;
    end
  end

  assign cfg_ready = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign out_vec   = out_q;

endmodule

// File: tb/tb_pla_cfg_loader.sv
// Directed-plus-random bench for pla_cfg_loader; expected PLA outputs come from
// a literal-by-literal model of the fuse map kept here.
module tb_pla_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_ready, cfg_done, cfg_err, busy;
  logic [2:0] in_vec = 3'b000;
  logic [1:0] out_vec;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] model_active = '0;

  // Terms {~x0&x1&x2, x0&~x1&x2, x0&x1&~x2, ~x0&~x1&x2}; out0 = t0|t1, out1 = t2|t3.
  localparam logic [31:0] GOOD_CFG = {8'b1100_0011, 24'b011010_100101_011001_010110};

  logic [2:0] dir_in  [6] = '{3'b110, 3'b101, 3'b011, 3'b100, 3'b000, 3'b111};
  logic [1:0] dir_exp [6] = '{2'b01,  2'b01,  2'b10,  2'b10,  2'b00,  2'b00};

  pla_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .in_vec    (in_vec),
    .out_vec   (out_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fuse index t*6 + 2i is the true literal, +1 the complement; OR fuse at 24 + 4o + t.
  function automatic logic [1:0] model_out(input logic [31:0] f, input logic [2:0] x);
    logic [1:0] r = 2'b00;
    for (int o = 0; o < 2; o++) begin
      for (int t = 0; t < 4; t++) begin
        int  lits = 0;
        bit  ok = 1'b1;
        if (f[24 + 4 * o + t]) begin
          for (int i = 0; i < 3; i++) begin
            if (f[6 * t + 2 * i])     begin lits++; if (!x[i]) ok = 1'b0; end
            if (f[6 * t + 2 * i + 1]) begin lits++; if (x[i])  ok = 1'b0; end
          end
          if (lits > 0 && ok) r[o] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic tick_chk(input string tag);
    logic [2:0] x = in_vec;
    step();
    check(tag, {30'd0, out_vec}, {30'd0, model_out(model_active, x)});
    check({tag, "_pulse"}, {30'd0, cfg_done, cfg_err}, 32'd0);
  endtask

  task automatic start_frame(input bit with_bit);
    cfg_start = 1'b1;
    cfg_valid = with_bit;
    cfg_bit   = 1'b1;
    in_vec    = 3'($urandom);
    tick_chk("start");
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("start_ready", {31'd0, cfg_ready}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic send_bits(input logic [31:0] f, input logic p, input bit gaps, input int nbits);
    int acc = 0;
    for (int k = 0; k < nbits; k++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
          cfg_valid = 1'b0;
          in_vec    = 3'($urandom);
          tick_chk("gap");
        end
      end
      cfg_valid = 1'b1;
      cfg_bit   = (k < 32) ? f[k] : p;
      in_vec    = 3'($urandom);
      if (cfg_ready) acc++;
      tick_chk("load");
    end
    cfg_valid = 1'b0;
    check("accepted", acc, nbits);
  endtask

  task automatic run_frame(input logic [31:0] f, input logic p, input bit gaps,
                           input bit start_in_check, input bit restart_bit);
    logic [2:0] x;
    bit         good;
    start_frame(restart_bit);
    send_bits(f, p, gaps, 33);
    check("chk_busy", {31'd0, busy}, 32'd1);
    check("chk_ready", {31'd0, cfg_ready}, 32'd0);
    check("chk_pulse", {30'd0, cfg_done, cfg_err}, 32'd0);
    x         = in_vec;
    cfg_start = start_in_check;
    cfg_valid = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    good = ((^f) ^ p) == 1'b0;
    check("done", {31'd0, cfg_done}, {31'd0, good});
    check("err", {31'd0, cfg_err}, {31'd0, !good});
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, cfg_ready}, 32'd0);
    check("old_out", {30'd0, out_vec}, {30'd0, model_out(model_active, x)});
    if (good) model_active = f;
    step();
    check("new_out", {30'd0, out_vec}, {30'd0, model_out(model_active, x)});
    check("post_pulse", {30'd0, cfg_done, cfg_err}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic dir_checks();
    for (int n = 0; n < 6; n++) begin
      in_vec = dir_in[n];
      step();
      check("dir", {30'd0, out_vec}, {30'd0, dir_exp[n]});
    end
  endtask

  task automatic rand_checks();
    for (int n = 0; n < 8; n++) begin
      in_vec = 3'($urandom);
      tick_chk("rand");
    end
  endtask

  initial begin
    logic [31:0] f;
    logic        p;

    // Reset with bits offered: nothing may be accepted or driven.
    rst_n     = 1'b0;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_vec = 3'($urandom);
      step();
      check("rst_ready", {31'd0, cfg_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out", {30'd0, out_vec}, 32'd0);
      check("rst_pulse", {30'd0, cfg_done, cfg_err}, 32'd0);
    end
    rst_n  = 1'b1;
    in_vec = 3'b111;
    step();
    check("idle_ignore", {31'd0, cfg_ready}, 32'd0);
    in_vec = 3'b110;
    step();
    check("unprog_out", {30'd0, out_vec}, 32'd0);
    cfg_valid = 1'b0;

    // Directed configuration, good parity.
    run_frame(GOOD_CFG, ^GOOD_CFG, 1'b0, 1'b0, 1'b0);
    dir_checks();

    // Same frame with inverted parity; start in CHECK must be ignored.
    run_frame(GOOD_CFG, ~^GOOD_CFG, 1'b0, 1'b1, 1'b0);
    dir_checks();

    // Random config, then the directed frame again with valid gaps.
    f = $urandom;
    run_frame(f, ^f, 1'b1, 1'b0, 1'b0);
    rand_checks();
    run_frame(GOOD_CFG, ^GOOD_CFG, 1'b1, 1'b0, 1'b0);
    dir_checks();

    // Restart after 10 bits; the restart cycle also offers a bit.
    f = $urandom;
    start_frame(1'b0);
    send_bits(f, ^f, 1'b0, 10);
    f = $urandom;
    run_frame(f, ^f, 1'b0, 1'b0, 1'b1);
    rand_checks();

    // Random frames with occasional bad parity.
    for (int n = 0; n < 4; n++) begin
      f = $urandom;
      p = (^f) ^ ($urandom_range(0, 3) == 0);
      run_frame(f, p, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      rand_checks();
    end

    // Reset 20 bits into a frame over a committed config.
    run_frame(GOOD_CFG, ^GOOD_CFG, 1'b0, 1'b0, 1'b0);
    f = $urandom;
    start_frame(1'b0);
    send_bits(f, ^f, 1'b0, 20);
    rst_n  = 1'b0;
    in_vec = 3'b110;
    step();
    rst_n = 1'b1;
    model_active = '0;
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_out", {30'd0, out_vec}, 32'd0);
    in_vec = 3'b110;
    step();
    check("cleared_out", {30'd0, out_vec}, 32'd0);
    check("cleared_ready", {31'd0, cfg_ready}, 32'd0);
    rand_checks();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pla_cfg_loader.md
Name: pla_cfg_loader

Overview:
- Programmable 3-input / 2-output PLA plus the serial configuration loader that writes its AND and OR fuse planes.
- Receives a serial fuse bitstream on a valid/ready handshake into a shadow fuse map and checks even parity.
- Commits the shadow map to the active planes atomically only when parity passes.
- Evaluates in_vec against the active planes into a registered out_vec; sits between the config master and the logic consuming the PLA outputs.

Parameters:
- N_IN, 3, number of PLA inputs.
- N_TERMS, 4, number of product terms.
- N_OUT, 2, number of PLA outputs.
- Derived: AND_BITS = N_TERMS*2*N_IN (24); OR_BITS = N_OUT*N_TERMS (8); FUSE_BITS = AND_BITS+OR_BITS (32).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_start  in  1  one-cycle pulse: begin or restart a configuration frame.
- cfg_valid  in  1  cfg_bit is valid.
- cfg_bit  in  1  serial fuse/parity bit.
- cfg_ready  out  1  loader accepts bits; high only in LOAD.
- cfg_done  out  1  one-cycle pulse: frame committed.
- cfg_err  out  1  one-cycle pulse: parity failure, frame discarded.
- busy  out  1  high in LOAD or CHECK.
- in_vec  in  N_IN  PLA inputs.
- out_vec  out  N_OUT  registered PLA outputs.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset values: state IDLE; bit counter 0; shadow and active planes all 0; cfg_ready, cfg_done, cfg_err, busy, out_vec all 0.
- States:
  - IDLE: cfg_start -> LOAD, clearing the counter, the shadow map and the parity accumulator.
  - LOAD: a bit is accepted on cfg_valid && cfg_ready.
    - Stream index k = counter value.
    - k < FUSE_BITS: store the bit at shadow[k] and fold it into parity.
    - k == FUSE_BITS: the bit is the parity bit; move to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE.
    - XOR of all 32 fuses and the parity bit == 0: copy shadow to active and pulse cfg_done on the next cycle.
    - Otherwise: pulse cfg_err on the next cycle; active planes unchanged.
- Fuse map:
  - AND term t, input i: true literal at index t*2*N_IN + 2*i; complement literal at index t*2*N_IN + 2*i + 1.
  - OR output o, term t: index AND_BITS + o*N_TERMS + t.
- Term evaluation:
  - A term is the AND of its enabled literals.
  - A term with no enabled literal evaluates to 0 (unused).
  - Enabling both literals of one input gives 0.
  - out_vec[o] = OR of the terms enabled in OR column o.
- Latency:
  - out_vec is registered from in_vec and the active planes: in_vec at edge n appears on out_vec after edge n+1.
  - A commit becomes visible in out_vec one cycle after cfg_done.
- Handshake:
  - cfg_ready is 0 outside LOAD; bits offered in IDLE/CHECK are ignored.
  - cfg_valid gaps in LOAD stall the counter.
- Boundary conditions:
  - cfg_start in LOAD restarts the frame: counter 0, shadow cleared, bit on that cycle ignored.
  - cfg_start in CHECK is ignored.
  - Reset mid-frame or mid-CHECK returns everything to reset values; the active planes are cleared too.
  - The PLA evaluates continuously during loading using the old active planes; no glitch at commit.

Decomposition:
- Package pla_pkg: N_IN/N_TERMS/N_OUT defaults, AND_BITS/OR_BITS/FUSE_BITS, state enum (IDLE, LOAD, CHECK), index helper functions for the AND/OR fuses.
- One combinational sub-module pla_eval: active AND/OR planes + in_vec -> next out_vec; the register stays in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with cfg_valid=1 -> cfg_ready=0, out_vec=2'b00, busy=0; any in_vec gives out_vec=0.
- Program terms {~x0&x1&x2, x0&~x1&x2, x0&x1&~x2, ~x0&~x1&x2}, out0=t0|t1, out1=t2|t3, correct parity:
  - cfg_done pulses once, 1 cycle after the parity bit.
  - in_vec=3'b110 -> out_vec=2'b01.
  - 3'b101 -> 01.
  - 3'b011 -> 10.
  - 3'b100 -> 10.
  - 3'b000 and 3'b111 -> 00.
- Same frame with inverted parity bit -> cfg_err pulse, no cfg_done; out_vec keeps the previous configuration's values.
- Random cfg_valid gaps (50% duty) during the good frame -> identical result; exactly 33 accepted bits.
- cfg_start asserted after 10 bits, then a full good frame -> only the second frame is committed; a single cfg_done.
- rst_n low after 20 bits of a frame over a committed config -> active planes cleared, out_vec=00; IDLE with cfg_ready=0.
